// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_gen_pkg;

  localparam int POS_W     = 10;
  localparam int POS_LIMIT = 1 << POS_W;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF =
    H_DISPLAY_DEF + H_FRONT_DEF +
    H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF =
    V_DISPLAY_DEF + V_FRONT_DEF +
    V_SYNC_DEF + V_BACK_DEF;

  localparam int FRAME_W_DEF = 10;

  function automatic logic sync_level(
    input logic asserted,
    input logic active_low
  );
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus registered active/sync flags.
// Flags are derived from the next position so they line up with pos.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int DISPLAY = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [POS_W-1:0] pos,
  output logic             active,
  output logic             sync_asserted,
  output logic             last
);

  localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;

  if (TOTAL > POS_LIMIT) begin : g_total_chk
    $error("axis total exceeds counter range");
  end

  localparam logic [POS_W-1:0] LAST_POS =
    POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] DISP_END =
    POS_W'(DISPLAY);
  localparam logic [POS_W-1:0] SYNC_BEG =
    POS_W'(DISPLAY + FRONT);
  localparam logic [POS_W-1:0] SYNC_END =
    POS_W'(DISPLAY + FRONT + SYNC);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             active_q, active_d;
  logic             sync_q, sync_d;

  assign last = (pos_q == LAST_POS);

  always_comb begin
    pos_d    = pos_q;
    active_d = active_q;
    sync_d   = sync_q;
    if (inc) begin
      pos_d    = last ? '0 : pos_q + 1'b1;
      active_d = (pos_d < DISP_END);
      sync_d   = (pos_d >= SYNC_BEG) &&
                 (pos_d < SYNC_END);
    end
  end

  // Parked on the last position so the first step lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= LAST_POS;
      active_q <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign pos           = pos_q;
  assign active        = active_q;
  assign sync_asserted = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: coordinates, active video, syncs, strobes.
// All outputs are aligned to the same pixel for the renderer.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int FRAME_W         = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  logic h_active, h_sync, h_last;
  logic v_active, v_sync, v_last;
  logic v_inc;

  assign v_inc = ce && h_last;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc           (ce),
    .pos           (hpos),
    .active        (h_active),
    .sync_asserted (h_sync),
    .last          (h_last)
  );

  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc           (v_inc),
    .pos           (vpos),
    .active        (v_active),
    .sync_asserted (v_sync),
    .last          (v_last)
  );

  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  always_comb begin
    line_start_d  = v_inc;
    frame_start_d = v_inc && v_last;
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign display_on  = h_active && v_active;
  assign hsync       = sync_level(h_sync, SYNC_ACTIVE_LOW);
  assign vsync       = sync_level(v_sync, SYNC_ACTIVE_LOW);
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size and shrunken raster instances
// checked every cycle against an arithmetic model of the raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  always #5 clk = ~clk;

  logic       hs0, vs0, de0, ls0, fs0;
  logic [9:0] h0, v0, fc0;
  logic       hs1, vs1, de1, ls1, fs1;
  logic [9:0] h1, v1;
  logic [3:0] fc1;

  vga_timing_gen u_full (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .hsync       (hs0),
    .vsync       (vs0),
    .display_on  (de0),
    .hpos        (h0),
    .vpos        (v0),
    .line_start  (ls0),
    .frame_start (fs0),
    .frame_count (fc0)
  );

  // 16x11 raster, active-high syncs, 4-bit frame counter.
  vga_timing_gen #(
    .H_DISPLAY       (8),
    .H_FRONT         (2),
    .H_SYNC          (3),
    .H_BACK          (3),
    .V_DISPLAY       (6),
    .V_FRONT         (1),
    .V_SYNC          (2),
    .V_BACK          (2),
    .SYNC_ACTIVE_LOW (1'b0),
    .FRAME_W         (4)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .hsync       (hs1),
    .vsync       (vs1),
    .display_on  (de1),
    .hpos        (h1),
    .vpos        (v1),
    .line_start  (ls1),
    .frame_start (fs1),
    .frame_count (fc1)
  );

  typedef struct packed {
    logic       hs, vs, de;
    logic [9:0] h, v;
    logic       ls, fs;
    logic [9:0] fc;
  } exp_t;

  int checks = 0;
  int failures = 0;

  longint n = 0;
  logic   en = 1'b0;

  // Enabled edges since reset, and whether the last edge was enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n  <= 0;
      en <= 1'b0;
    end else begin
      en <= ce;
      if (ce) n <= n + 1;
    end
  end

  function automatic exp_t model(
    input longint cnt, input logic last_en,
    input int hd, input int hf, input int hsw, input int hb,
    input int vd, input int vf, input int vsw, input int vb,
    input logic al, input int fw
  );
    exp_t   e;
    longint ht, vt, p, h, v, fr;
    logic   hsa, vsa;
    ht = longint'(hd + hf + hsw + hb);
    vt = longint'(vd + vf + vsw + vb);
    if (cnt == 0) begin
      e.h  = 10'(ht - 1);
      e.v  = 10'(vt - 1);
      e.de = 1'b0;
      e.hs = al;
      e.vs = al;
      e.ls = 1'b0;
      e.fs = 1'b0;
      e.fc = '0;
      return e;
    end
    p   = (cnt - 1) % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    fr  = ((cnt - 1) / (ht * vt) + 1) % (longint'(1) << fw);
    hsa = (h >= hd + hf) && (h < hd + hf + hsw);
    vsa = (v >= vd + vf) && (v < vd + vf + vsw);
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.de = (h < hd) && (v < vd);
    e.hs = al ? !hsa : hsa;
    e.vs = al ? !vsa : vsa;
    e.ls = last_en && (h == 0);
    e.fs = last_en && (p == 0);
    e.fc = 10'(fr);
    return e;
  endfunction

  task automatic cmp(input string name,
                     input logic [9:0] act,
                     input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s act=%0d exp=%0d t=%0t",
                 name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s act=timeout exp=event", name);
  endtask

  task automatic check_all();
    exp_t e0, e1;
    e0 = model(n, en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 10);
    e1 = model(n, en, 8, 2, 3, 3, 6, 1, 2, 2, 1'b0, 4);
    cmp("f_hpos", h0, e0.h);
    cmp("f_vpos", v0, e0.v);
    cmp("f_de", 10'(de0), 10'(e0.de));
    cmp("f_hsync", 10'(hs0), 10'(e0.hs));
    cmp("f_vsync", 10'(vs0), 10'(e0.vs));
    cmp("f_line", 10'(ls0), 10'(e0.ls));
    cmp("f_frame", 10'(fs0), 10'(e0.fs));
    cmp("f_fcnt", fc0, e0.fc);
    cmp("s_hpos", h1, e1.h);
    cmp("s_vpos", v1, e1.v);
    cmp("s_de", 10'(de1), 10'(e1.de));
    cmp("s_hsync", 10'(hs1), 10'(e1.hs));
    cmp("s_vsync", 10'(vs1), 10'(e1.vs));
    cmp("s_line", 10'(ls1), 10'(e1.ls));
    cmp("s_frame", 10'(fs1), 10'(e1.fs));
    cmp("s_fcnt", 10'(fc1), e1.fc);
  endtask

  always @(negedge clk) check_all();

  initial begin
    int cnt_a, cnt_b, k;
    rst_n = 1'b0;
    ce    = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst_hpos", h0, 10'd799);
    cmp("rst_vpos", v0, 10'd524);
    cmp("rst_hsync", 10'(hs0), 10'd1);
    cmp("rst_fcnt", fc0, 10'd0);

    ce    = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    cmp("hold_hpos", h0, 10'd799);
    ce = 1'b1;
    @(negedge clk);
    cmp("first_hpos", h0, 10'd0);
    cmp("first_vpos", v0, 10'd0);
    cmp("first_de", 10'(de0), 10'd1);
    cmp("first_fs", 10'(fs0), 10'd1);
    cmp("first_ls", 10'(ls0), 10'd1);
    cmp("first_fcnt", fc0, 10'd1);

    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (!hs0) cnt_a++;
      if (ls0) cnt_b++;
    end
    cmp("line_hsync_clks", 10'(cnt_a), 10'd96);
    cmp("line_ls_count", 10'(cnt_b), 10'd1);

    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 176; i++) begin
      @(negedge clk);
      if (vs1) cnt_a++;
      if (fs1) cnt_b++;
    end
    cmp("frame_vsync_clks", 10'(cnt_a), 10'd32);
    cmp("frame_fs_count", 10'(cnt_b), 10'd1);

    // ce toggling: frame period doubles.
    k = 0;
    while (!fs1 && k < 1000) begin
      @(negedge clk);
      ce = ~ce;
      k++;
    end
    if (k >= 1000) timeout("toggle_sync");
    k = 0;
    do begin
      @(negedge clk);
      ce = ~ce;
      k++;
    end while (!fs1 && k < 1000);
    if (k >= 1000) timeout("toggle_period");
    else cmp("toggle_period", 10'(k), 10'd352);

    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      ce = ($urandom_range(0, 3) != 0);
    end

    ce = 1'b1;
    k = 0;
    while (!(fs1 && fc1 == 4'd15) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) timeout("wrap_wait15");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fs1 && k < 400);
    if (k >= 400) timeout("wrap_wait0");
    cmp("wrap_fcnt", 10'(fc1), 10'd0);
    cmp("wrap_hpos", h1, 10'd0);
    cmp("wrap_vpos", v1, 10'd0);

    k = 0;
    while (h0 != 10'd700 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) timeout("f_reset_wait");
    cmp("pre_rst_hsync", 10'(hs0), 10'd0);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_f_hsync", 10'(hs0), 10'd1);
    cmp("arst_f_hpos", h0, 10'd799);
    cmp("arst_f_vpos", v0, 10'd524);
    cmp("arst_f_fcnt", fc0, 10'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    k = 0;
    while (!(h1 == 10'd11 && v1 == 10'd7) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) timeout("s_reset_wait");
    cmp("pre_rst_vsync", 10'(vs1), 10'd1);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_s_hsync", 10'(hs1), 10'd0);
    cmp("arst_s_vsync", 10'(vs1), 10'd0);
    cmp("arst_s_hpos", h1, 10'd15);
    cmp("arst_s_vpos", v1, 10'd10);
    cmp("arst_s_fcnt", 10'(fc1), 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("restart_hpos", h1, 10'd0);
    cmp("restart_vpos", v1, 10'd0);
    cmp("restart_fs", 10'(fs1), 10'd1);
    cmp("restart_fcnt", 10'(fc1), 10'd1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ce = ($urandom_range(0, 1) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
